// File: rtl/booth_pkg.sv
// Shared definitions for the Booth product accumulator: default widths,
// FSM state encoding and the signed saturation limits at the default width.
// Optional build macro: ACC_SAT_EN (saturating accumulation, see booth_acc_add).
package booth_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_ACC_W = 24;
    localparam int DEF_CNT_W = 8;

    // IDLE: no partial sum held; ACCUM: a frame is in progress
    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_t;

    localparam logic [DEF_ACC_W-1:0] ACC_MAX = {1'b0, {(DEF_ACC_W-1){1'b1}}};
    localparam logic [DEF_ACC_W-1:0] ACC_MIN = {1'b1, {(DEF_ACC_W-1){1'b0}}};

endpackage

// File: rtl/booth_prod_accum_if.sv
// Product-stream and result-buffer signals of the Booth product accumulator.
// The master modport is the side that feeds products and takes results; the
// slave modport is the accumulator itself.
interface booth_prod_accum_if
    import booth_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ACC_W = DEF_ACC_W,
    parameter int CNT_W = DEF_CNT_W
);

    logic [2*WIDTH-1:0] prod_in;
    logic               prod_valid;
    logic               prod_last;
    logic               in_ready;
    logic [ACC_W-1:0]   acc_out;
    logic [CNT_W-1:0]   acc_cnt;
    logic               acc_ovf;
    logic               acc_valid;
    logic               acc_ready;

    modport master (
        output prod_in, prod_valid, prod_last, acc_ready,
        input  in_ready, acc_out, acc_cnt, acc_ovf, acc_valid
    );

    modport slave (
        input  prod_in, prod_valid, prod_last, acc_ready,
        output in_ready, acc_out, acc_cnt, acc_ovf, acc_valid
    );

endinterface

// File: rtl/booth_acc_add.sv
// Combinational extend/add/overflow unit. The running sum and the incoming
// product are both widened by one guard bit so that a signed overflow of the
// ACC_W-bit accumulator shows up as a disagreement of the top two sum bits.
// Optional build macro: ACC_SAT_EN clamps an overflowed sum to the signed
// limit selected by the true sign (the guard bit); otherwise the sum wraps.
module booth_acc_add #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 24
) (
    input  logic [ACC_W-1:0]   acc_i,
    input  logic [2*WIDTH-1:0] prod_i,
    output logic [ACC_W-1:0]   sum_o,
    output logic               ovf_o
);

    logic [ACC_W:0] accExt;
    logic [ACC_W:0] prodExt;
    logic [ACC_W:0] sumFull;

    assign accExt  = {acc_i[ACC_W-1], acc_i};
    assign prodExt = {{(ACC_W+1-2*WIDTH){prod_i[2*WIDTH-1]}}, prod_i};
    assign sumFull = accExt + prodExt;
    assign ovf_o   = sumFull[ACC_W] ^ sumFull[ACC_W-1];

`ifdef ACC_SAT_EN
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Clamp toward the true sign when the guard bit disagrees with the MSB
    always_comb begin
        sum_o = sumFull[ACC_W-1:0];
        if (ovf_o) begin
            sum_o = sumFull[ACC_W] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign sum_o = sumFull[ACC_W-1:0];
`endif

endmodule

// File: rtl/booth_prod_accum.sv
// Accumulate stage behind the pipelined radix-4 Booth multiplier. Products of
// a frame are summed into an ACC_W-bit register; the final term of a frame
// loads a one-entry result buffer (sum, term count, sticky overflow) that is
// drained with a valid/ready handshake. Non-last terms keep accumulating while
// the buffer waits, and input is refused only while a full buffer is stalled.
// Optional build macro: ACC_SAT_EN (saturating instead of wrapping sums).
module booth_prod_accum
    import booth_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ACC_W = DEF_ACC_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                CLK,
    input  logic                RST,
    booth_prod_accum_if.slave   bus
);

    acc_state_t       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W-1:0] accOut_q, accOut_d;
    logic [CNT_W-1:0] accCnt_q, accCnt_d;
    logic             accOvf_q, accOvf_d;
    logic             accValid_q, accValid_d;

    logic             inReady;
    logic             accept;
    logic             xfer;
    logic [ACC_W-1:0] addBase;
    logic [ACC_W-1:0] addSum;
    logic             addOvf;
    logic [CNT_W-1:0] cntInc;

    assign inReady = !(accValid_q && !bus.acc_ready);
    assign accept  = bus.prod_valid && inReady;
    assign xfer    = accValid_q && bus.acc_ready;
    assign addBase = (state_q == IDLE) ? '0 : acc_q;
    assign cntInc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    booth_acc_add #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
    ) u_add (
        .acc_i  (addBase),
        .prod_i (bus.prod_in),
        .sum_o  (addSum),
        .ovf_o  (addOvf)
    );

    // Frame FSM and result buffer next-state: accumulate, or close the frame
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        accOut_d   = accOut_q;
        accCnt_d   = accCnt_q;
        accOvf_d   = accOvf_q;
        accValid_d = accValid_q && !xfer;

        if (accept) begin
            if (bus.prod_last) begin
                accOut_d   = addSum;
                accCnt_d   = cntInc;
                accOvf_d   = ((state_q == ACCUM) && ovf_q) || addOvf;
                accValid_d = 1'b1;
                acc_d      = '0;
                cnt_d      = '0;
                ovf_d      = 1'b0;
                state_d    = IDLE;
            end else begin
                acc_d   = addSum;
                cnt_d   = cntInc;
                ovf_d   = ((state_q == ACCUM) && ovf_q) || addOvf;
                state_d = ACCUM;
            end
        end
    end

    // State, partial-sum and result-buffer registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            accOut_q   <= '0;
            accCnt_q   <= '0;
            accOvf_q   <= 1'b0;
            accValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            accOut_q   <= accOut_d;
            accCnt_q   <= accCnt_d;
            accOvf_q   <= accOvf_d;
            accValid_q <= accValid_d;
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.acc_out   = accOut_q;
    assign bus.acc_cnt   = accCnt_q;
    assign bus.acc_ovf   = accOvf_q;
    assign bus.acc_valid = accValid_q;

endmodule

// File: tb/tb_booth_prod_accum.sv
// Self-checking bench for booth_prod_accum: a vector table of frames, a
// long overflowing frame, and hand-written handshake/reset sequences.
// Completed-frame expectations go into a scoreboard queue and are compared
// whenever the DUT hands a result downstream.
module tb_booth_prod_accum;
    import booth_pkg::*;

    typedef struct {
        logic [15:0] prod;
        logic        last;
        logic [23:0] expOut;
        logic [7:0]  expCnt;
        logic        expOvf;
    } vec_t;

    typedef struct {
        logic [23:0] out;
        logic [7:0]  cnt;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   nChecks;
    int   nFail;
    exp_t sb[$];
    vec_t vecs[9];

    booth_prod_accum_if #(.WIDTH(8), .ACC_W(24), .CNT_W(8)) bus ();

    booth_prod_accum #(
        .WIDTH (8),
        .ACC_W (24),
        .CNT_W (8)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop if something hangs
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pushExpected(input logic [23:0] o, input logic [7:0] c, input logic v);
        exp_t e;
        e.out = o;
        e.cnt = c;
        e.ovf = v;
        sb.push_back(e);
    endtask

    // Present one term for one clock edge, then return #1 after that edge
    task automatic applyStimulus(input logic [15:0] p, input logic l);
        bus.prod_in    = p;
        bus.prod_valid = 1'b1;
        bus.prod_last  = l;
        @(posedge clk);
        #1;
        bus.prod_valid = 1'b0;
        bus.prod_last  = 1'b0;
    endtask

    // Scoreboard: compare each result as it is handed downstream
    always @(negedge clk) begin
        if (!rst && bus.acc_valid && bus.acc_ready) begin
            if (sb.size() == 0) begin
                nChecks++;
                nFail++;
                $display("[TB] FAIL unexpected_result: got 0x%0h, expected no result", bus.acc_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("sb_acc_out", 32'(bus.acc_out), 32'(e.out));
                checkOutput("sb_acc_cnt", 32'(bus.acc_cnt), 32'(e.cnt));
                checkOutput("sb_acc_ovf", 32'(bus.acc_ovf), 32'(e.ovf));
            end
        end
    end

    initial begin
        logic [23:0] bigExp;

        nChecks = 0;
        nFail   = 0;

        vecs[0] = '{16'h3F01, 1'b0, 24'h0, 8'h0, 1'b0};
        vecs[1] = '{16'h3F01, 1'b0, 24'h0, 8'h0, 1'b0};
        vecs[2] = '{16'h3F01, 1'b1, 24'h00BD03, 8'd3, 1'b0};
        vecs[3] = '{16'hFF80, 1'b0, 24'h0, 8'h0, 1'b0};
        vecs[4] = '{16'h0010, 1'b1, 24'hFFFF90, 8'd2, 1'b0};
        vecs[5] = '{16'h8000, 1'b1, 24'hFF8000, 8'd1, 1'b0};
        vecs[6] = '{16'h1234, 1'b0, 24'h0, 8'h0, 1'b0};
        vecs[7] = '{16'hEDCC, 1'b0, 24'h0, 8'h0, 1'b0};
        vecs[8] = '{16'h7FFF, 1'b1, 24'h007FFF, 8'd3, 1'b0};

        rst            = 1'b1;
        bus.prod_in    = '0;
        bus.prod_valid = 1'b0;
        bus.prod_last  = 1'b0;
        bus.acc_ready  = 1'b1;

        // Reset values
        #12;
        checkOutput("rst_acc_out", 32'(bus.acc_out), 32'h0);
        checkOutput("rst_acc_cnt", 32'(bus.acc_cnt), 32'h0);
        checkOutput("rst_acc_ovf", 32'(bus.acc_ovf), 32'h0);
        checkOutput("rst_acc_valid", 32'(bus.acc_valid), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'h1);
        @(posedge clk);
        #1;

        // Table of frames with acc_ready held high
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].last) pushExpected(vecs[i].expOut, vecs[i].expCnt, vecs[i].expOvf);
            applyStimulus(vecs[i].prod, vecs[i].last);
            checkOutput($sformatf("vec%0d_valid", i), 32'(bus.acc_valid), 32'(vecs[i].last));
        end

        // 512 x 0x4000 reaches exactly 2^23: overflow and a saturated count
`ifdef ACC_SAT_EN
        bigExp = ACC_MAX;
`else
        bigExp = 24'h800000;
`endif
        pushExpected(bigExp, 8'hFF, 1'b1);
        for (int i = 0; i < 512; i++) begin
            applyStimulus(16'h4000, (i == 511));
        end
        checkOutput("big_acc_out", 32'(bus.acc_out), 32'(bigExp));
        checkOutput("big_acc_ovf", 32'(bus.acc_ovf), 32'h1);
        @(posedge clk);
        #1;

        // Backpressure: stalled buffer refuses and drops a new product
        bus.acc_ready = 1'b0;
        pushExpected(24'h000005, 8'd1, 1'b0);
        applyStimulus(16'h0005, 1'b1);
        checkOutput("bp_valid", 32'(bus.acc_valid), 32'h1);
        checkOutput("bp_in_ready_low", 32'(bus.in_ready), 32'h0);
        applyStimulus(16'h0007, 1'b1);
        checkOutput("bp_hold_out", 32'(bus.acc_out), 32'h000005);
        checkOutput("bp_hold_cnt", 32'(bus.acc_cnt), 32'h1);
        checkOutput("bp_still_stalled", 32'(bus.in_ready), 32'h0);
        bus.acc_ready = 1'b1;
        #1;
        checkOutput("bp_in_ready_back", 32'(bus.in_ready), 32'h1);
        @(posedge clk);
        #1;
        checkOutput("bp_drained", 32'(bus.acc_valid), 32'h0);
        pushExpected(24'h000007, 8'd1, 1'b0);
        applyStimulus(16'h0007, 1'b1);
        checkOutput("bp_resend_out", 32'(bus.acc_out), 32'h000007);
        @(posedge clk);
        #1;

        // Transfer and reload in the same cycle
        pushExpected(24'h000001, 8'd1, 1'b0);
        pushExpected(24'h000002, 8'd1, 1'b0);
        applyStimulus(16'h0001, 1'b1);
        checkOutput("b2b_first_valid", 32'(bus.acc_valid), 32'h1);
        checkOutput("b2b_first_out", 32'(bus.acc_out), 32'h000001);
        applyStimulus(16'h0002, 1'b1);
        checkOutput("b2b_second_valid", 32'(bus.acc_valid), 32'h1);
        checkOutput("b2b_second_out", 32'(bus.acc_out), 32'h000002);
        @(posedge clk);
        #1;
        checkOutput("b2b_drained", 32'(bus.acc_valid), 32'h0);
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a frame discards the partial sum
        applyStimulus(16'h0100, 1'b0);
        applyStimulus(16'h0200, 1'b0);
        rst = 1'b1;
        #2;
        checkOutput("midrst_valid", 32'(bus.acc_valid), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        pushExpected(24'h000003, 8'd1, 1'b0);
        applyStimulus(16'h0003, 1'b1);
        checkOutput("midrst_out", 32'(bus.acc_out), 32'h000003);
        checkOutput("midrst_cnt", 32'(bus.acc_cnt), 32'h1);

        // Let the scoreboard drain, bounded
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(posedge clk);
        end
        #1;
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/booth_prod_accum.md
Name: booth_prod_accum

Overview:
- Downstream stage of the 4-stage pipelined radix-4 Booth multiplier (mb8_top).
- Consumes its 2*WIDTH-bit signed product stream, with a valid/last sideband delayed by the multiplier's 4-cycle latency, and accumulates dot-product frames into an ACC_W-bit register.
- Completed sums go to a one-entry output buffer with a valid/ready handshake, a term count and an overflow flag.
- Forms the accumulate half of a MAC lane in the AI-SOC datapath.

Parameters:
- WIDTH, 8, multiplier operand width; product input is 2*WIDTH bits.
- ACC_W, 24, accumulator/result width; must be >= 2*WIDTH.
- CNT_W, 8, term-counter width.

Ports:
- CLK  in  1  clock; all state on rising edge.
- RST  in  1  reset, asynchronous, active-high; clears all state.
- prod_in  in  2*WIDTH  signed two's-complement product from the multiplier.
- prod_valid  in  1  prod_in valid this cycle.
- prod_last  in  1  prod_in is the final term of the current frame.
- in_ready  out  1  block accepts prod_in this cycle.
- acc_out  out  ACC_W  completed frame sum.
- acc_cnt  out  CNT_W  number of terms in the completed frame.
- acc_ovf  out  1  frame overflowed ACC_W signed range.
- acc_valid  out  1  output buffer holds a result.
- acc_ready  in  1  downstream takes the result.

Behaviour:
- Reset: acc_out=0, acc_cnt=0, acc_ovf=0, acc_valid=0, internal acc=0, term count=0, sticky ovf=0, state=IDLE. in_ready is 1 once reset is released.
- Accept: accept = prod_valid && in_ready. When prod_valid=0, nothing changes except the output handshake.
- in_ready = !(acc_valid && !acc_ready). It is combinational and drops only while a full buffer is stalled.
  - The multiplier cannot stall, so the integrator must guarantee no products arrive while in_ready=0.
  - A product presented with in_ready=0 is dropped.
- Width rule:
  - prod_in is sign-extended to ACC_W+1 bits.
  - sum = acc + sext(prod_in) is computed at ACC_W+1 bits.
  - Overflow occurs when the top two bits of sum differ. It sets the sticky ovf for the frame.
- State machine:
  - IDLE: accept without last → acc=sext(prod), cnt=1 → ACCUM. Accept with last → buffer loaded directly (single-term frame), stay IDLE.
  - ACCUM: accept without last → acc=sum, cnt+1 (saturating at 2^CNT_W-1). Accept with last → buffer loaded, acc/cnt/ovf cleared → IDLE.
- Buffer load: acc_out=sum[ACC_W-1:0] (or the saturated value), acc_cnt=cnt+1 (saturating), acc_ovf=ovf|this-cycle overflow, acc_valid=1.
- Latency: a last term accepted on edge N gives acc_valid=1 after edge N, i.e. visible in cycle N+1.
- Handshake:
  - acc_valid is held and acc_out/acc_cnt/acc_ovf are stable until acc_valid&&acc_ready.
  - A completed transfer with no load in the same cycle → acc_valid=0.
  - Transfer and new load in the same cycle → buffer reloads, acc_valid stays 1.
- Non-last terms are accepted even while the buffer is full but not stalled. Accumulation overlaps output wait.
- Reset mid-frame discards the partial sum and any buffered result.

Optional Feature:
- Macro ACC_SAT_EN.
- Defined: on overflow the accumulator clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1), by the sign of the top bit of sum. Later terms add to the clamped value. acc_ovf is still reported.
- Undefined: two's-complement wrap; acc_ovf is reported only.

Decomposition:
- Shared package (booth_pkg): WIDTH/ACC_W/CNT_W defaults, the state enum {IDLE, ACCUM}, and ACC_MAX/ACC_MIN constants.
- One natural sub-module: booth_acc_add, the combinational (ACC_W+1)-bit extend/add/overflow/saturate unit.
- The FSM, counter and output buffer stay in the top module.

Test Plan:
- Three terms 0x3F01 (0x7F*0x7F), last on the third, acc_ready=1 → acc_out=0x00BD03, acc_cnt=3, acc_ovf=0; acc_valid high exactly one cycle after the last accept.
- Terms 0xFF80 (-128), 0x0010 (16, last) → acc_out=0xFFFF90 (-112), acc_cnt=2.
- 512 terms of 0x4000, last on the 512th → sum 0x800000, acc_ovf=1, acc_cnt=0xFF (saturated). With ACC_SAT_EN → acc_out=0x7FFFFF; without → acc_out=0x800000.
- Backpressure:
  - Single-term frames 0x0005 and 0x0007 with acc_ready=0 → the first is buffered and in_ready=0. The second is presented while in_ready=0 and is dropped.
  - Raise acc_ready → the 0x0005 result transfers and in_ready returns to 1 in the same cycle.
  - Present 0x0007 again with acc_ready=1 → acc_out=0x000007 next cycle.
- Transfer and reload in the same cycle with acc_ready=1 → back-to-back single-term frames 0x0001, 0x0002 give acc_valid continuously high, acc_out 0x000001 then 0x000002.
- Assert RST mid-frame after two terms, then send 0x0003 with last → acc_out=0x000003, acc_cnt=1; the partial sum is gone.
